// File: rtl/nibble_serial_adder.sv
// Serial adder: one carry-lookahead nibble per cycle, LSB first.
// Optional macro SIGNED_OVF_EN adds the registered signed-overflow output Ovf.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SIGNED_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = $clog2(NIB);
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             cy_q, cy_d;
    logic             cout_q, cout_d;
`ifdef SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [3:0] an, bn, p, g, sn;
    logic       c1, c2, c3, c4;

    // Lookahead: every nibble carry is a flat function of G/P and cy_q.
    always_comb begin
        an = a_q[{idx_q, 2'b00} +: 4];
        bn = b_q[{idx_q, 2'b00} +: 4];
        p  = an ^ bn;
        g  = an & bn;
        c1 = g[0] | (p[0] & cy_q);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy_q);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cy_q);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cy_q);
        sn = p ^ {c3, c2, c1, cy_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = BUSY;
            BUSY: if (idx_q == LAST) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sum_d  = sum_q;
        idx_d  = idx_q;
        cy_d   = cy_q;
        cout_d = cout_q;
`ifdef SIGNED_OVF_EN
        ovf_d  = ovf_q;
`endif
        if (state_q == IDLE && in_valid) begin
            a_d   = A;
            b_d   = B;
            cy_d  = Cin;
            idx_d = '0;
        end else if (state_q == BUSY) begin
            sum_d[{idx_q, 2'b00} +: 4] = sn;
            cy_d  = c4;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) begin
                cout_d = c4;
`ifdef SIGNED_OVF_EN
                ovf_d  = c3 ^ c4;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx_q  <= '0;
            cy_q   <= 1'b0;
            cout_q <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
            idx_q  <= idx_d;
            cy_q   <= cy_d;
            cout_q <= cout_d;
`ifdef SIGNED_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
`ifdef SIGNED_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule
